rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024: consecutive clk_locked-high cycles required before any reset is released.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles between releasing the peripheral reset and releasing the core reset.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: cycles allowed for init_done (used only under RST_SEQ_TIMEOUT_EN).
REQ-004 SHALL have port clk_p, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_p, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port clk_locked, input, 1: clock-generator lock status; assumed synchronous to clk_p.
REQ-007 SHALL have port soft_rst_req, input, 1: single-cycle software reset request.
REQ-008 SHALL have port init_done, input, 1: level from the datapath indicating initialisation is complete.
REQ-009 SHALL have port rst_n_out, output, 1: active-low peripheral reset, driving the top wrapper RST input.
REQ-010 SHALL have port core_rst, output, 1: active-high core reset.
REQ-011 SHALL have port init_start, output, 1: one-cycle initialisation strobe.
REQ-012 SHALL have port ready, output, 1: system running.
REQ-013 SHALL have port init_err, output, 1: sticky initialisation-timeout flag.
REQ-014 SHALL have port state_o, output, 3: current state encoding, for debug.

Function
REQ-015 SHALL implement states WAIT_LOCK=0, STABLE=1, REL_PERIPH=2, REL_CORE=3, INIT=4, RUN=5, FAULT=6.
REQ-016 WAIT_LOCK SHALL do the following:
  - hold rst_n_out=0 and core_rst=1;
  - on clk_locked=1, load the counter with LOCK_CYCLES-1 and go to STABLE.
REQ-017 STABLE SHALL behave as follows:
  - decrement the counter while clk_locked=1;
  - at counter 0, go to REL_PERIPH, with rst_n_out=1 from that edge;
  - total from first lock cycle to rst_n_out rise is LOCK_CYCLES+1 cycles.
REQ-018 REL_PERIPH SHALL hold core_rst=1 for HOLD_CYCLES cycles, then go to REL_CORE.
REQ-019 REL_CORE SHALL last one cycle with core_rst=0, then go to INIT.
REQ-020 init_start SHALL be 1 exactly in the first INIT cycle and 0 otherwise.
REQ-021 INIT SHALL go to RUN on the first cycle init_done=1 is sampled, including the init_start cycle.
REQ-022 RUN SHALL assert ready=1; ready SHALL be 0 in every other state.
REQ-023 Event priority, highest first:
  - clk_locked=0 in any state except WAIT_LOCK: go to WAIT_LOCK, reasserting rst_n_out=0 and core_rst=1 on that edge;
  - soft_rst_req=1 in REL_PERIPH..RUN or FAULT: reassert both resets, reload the counter, go to STABLE;
  - normal transition.
REQ-024 soft_rst_req in WAIT_LOCK or STABLE SHALL be ignored.
REQ-025 All counters SHALL use width $clog2 of the largest parameter plus 1, and SHALL never wrap.
REQ-026 Parameters below 1 SHALL be treated as 1.

Reset
REQ-027 On reset_p=1, asynchronously and independently of the clock, the block SHALL force:
  - state=WAIT_LOCK, counter=0;
  - rst_n_out=0, core_rst=1;
  - init_start=0, ready=0, init_err=0.
REQ-028 Reset deassertion SHALL take effect on the next clk_p edge with no extra delay cycles.

Configuration
REQ-029 With macro RST_SEQ_TIMEOUT_EN defined, the block SHALL implement the init timeout:
  - INIT loads a timeout counter with TIMEOUT_CYCLES;
  - if it expires without init_done, go to FAULT and set init_err=1;
  - FAULT holds core_rst=1 and rst_n_out=1;
  - FAULT is left only via soft_rst_req or lock loss;
  - init_err clears only on reset_p or soft_rst_req.
REQ-030 Without RST_SEQ_TIMEOUT_EN, INIT SHALL wait indefinitely, init_err SHALL be tied 0, and FAULT SHALL be unreachable.

Structure
REQ-031 A shared package rst_seq_pkg SHALL hold:
  - the state typedef and encodings;
  - default constants for LOCK_CYCLES, HOLD_CYCLES and TIMEOUT_CYCLES.
REQ-032 A sub-module rst_seq_cnt SHALL provide a loadable down-counter with a zero flag, instantiated for the lock/hold count and (under the macro) the timeout count.

Verification
Bench parameters: LOCK_CYCLES=8, HOLD_CYCLES=4, TIMEOUT_CYCLES=32.
REQ-033 The bench SHALL cover cold boot:
  - stimulus: reset_p pulse, clk_locked=1 from cycle 0, init_done rising 3 cycles after init_start;
  - response: rst_n_out rises at cycle 9, core_rst falls at cycle 13, init_start pulses at cycle 14, ready=1 at cycle 18.
REQ-034 The bench SHALL cover lock glitch: clk_locked drops for 1 cycle in STABLE at counter=3 -> WAIT_LOCK, and a full 8-cycle count restarts after relock.
REQ-035 The bench SHALL cover soft reset in RUN: soft_rst_req pulse -> ready=0, rst_n_out=0 and core_rst=1 on the next edge, then the REQ-033 sequence repeats (rst_n_out high 9 cycles later).
REQ-036 The bench SHALL cover priority: soft_rst_req and clk_locked=0 asserted in the same RUN cycle -> state_o=0 (WAIT_LOCK).
REQ-037 The bench SHALL cover the timeout, with RST_SEQ_TIMEOUT_EN defined and init_done held 0:
  - FAULT with init_err=1 32 cycles after INIT entry;
  - a subsequent soft_rst_req clears init_err.
REQ-038 The bench SHALL cover asynchronous reset mid-INIT: reset_p asserted between clock edges -> all outputs at REQ-027 values before the next clk_p edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// State encodings are fixed because state_o exposes them for debug.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK  = 3'd0,
    S_STABLE     = 3'd1,
    S_REL_PERIPH = 3'd2,
    S_REL_CORE   = 3'd3,
    S_INIT       = 3'd4,
    S_RUN        = 3'd5,
    S_FAULT      = 3'd6
  } state_e;

  localparam int DEF_LOCK_CYCLES    = 1024;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable saturating down-counter with zero and last-count flags.
// Load wins over decrement; the count never wraps below zero.
module rst_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-on / soft reset sequencer: lock wait, peripheral then core release, init.
// Define RST_SEQ_TIMEOUT_EN to enable the init timeout and FAULT state.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_p,
  input  logic       reset_p,
  input  logic       clk_locked,
  input  logic       soft_rst_req,
  input  logic       init_done,
  output logic       rst_n_out,
  output logic       core_rst,
  output logic       init_start,
  output logic       ready,
  output logic       init_err,
  output logic [2:0] state_o
);

  localparam int LOCK_C = clamp1(LOCK_CYCLES);
  localparam int HOLD_C = clamp1(HOLD_CYCLES);
  localparam int TMO_C  = clamp1(TIMEOUT_CYCLES);
  localparam int CW     = $clog2(max3(LOCK_C, HOLD_C, TMO_C)) + 1;

  localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_C - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_C - 1);

  state_e        r_state;
  state_e        w_nxt;
  logic          r_rst_n;
  logic          r_core_rst;
  logic          r_init_start;
  logic          r_ready;

  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_val;
  logic          w_cnt_dec;
  logic          w_cnt_zero;
  logic          w_cnt_last_unused;
  logic          w_periph_on;
  logic          w_core_on;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LD = CW'(TMO_C);

  logic w_tmo_load;
  logic w_tmo_dec;
  logic w_tmo_last;
  logic w_tmo_zero_unused;
  logic w_err_set;
  logic w_err_clr;
  logic r_init_err;
`endif

  rst_seq_cnt #(.W(CW)) u_cnt (
    .clk    (clk_p),
    .rst    (reset_p),
    .i_load (w_cnt_load),
    .i_val  (w_cnt_val),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero),
    .o_last (w_cnt_last_unused)
  );

`ifdef RST_SEQ_TIMEOUT_EN
  rst_seq_cnt #(.W(CW)) u_tmo (
    .clk    (clk_p),
    .rst    (reset_p),
    .i_load (w_tmo_load),
    .i_val  (TMO_LD),
    .i_dec  (w_tmo_dec),
    .o_zero (w_tmo_zero_unused),
    .o_last (w_tmo_last)
  );
`endif

  always_comb begin
    w_nxt      = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = LOCK_LD;
    w_cnt_dec  = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    w_tmo_load = 1'b0;
    w_tmo_dec  = 1'b0;
    w_err_set  = 1'b0;
    w_err_clr  = 1'b0;
`endif
    if ((r_state != S_WAIT_LOCK) && !clk_locked) begin
      w_nxt = S_WAIT_LOCK;
    end else if (soft_rst_req && (r_state != S_WAIT_LOCK) &&
                 (r_state != S_STABLE)) begin
      w_nxt      = S_STABLE;
      w_cnt_load = 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
      w_err_clr  = 1'b1;
`endif
    end else begin
      unique case (r_state)
        S_WAIT_LOCK: begin
          if (clk_locked) begin
            w_nxt      = S_STABLE;
            w_cnt_load = 1'b1;
          end
        end
        S_STABLE: begin
          if (w_cnt_zero) begin
            w_nxt      = S_REL_PERIPH;
            w_cnt_load = 1'b1;
            w_cnt_val  = HOLD_LD;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        S_REL_PERIPH: begin
          if (w_cnt_zero) w_nxt = S_REL_CORE;
          else            w_cnt_dec = 1'b1;
        end
        S_REL_CORE: begin
          w_nxt = S_INIT;
`ifdef RST_SEQ_TIMEOUT_EN
          w_tmo_load = 1'b1;
`endif
        end
        S_INIT: begin
          if (init_done) begin
            w_nxt = S_RUN;
`ifdef RST_SEQ_TIMEOUT_EN
          end else if (w_tmo_last) begin
            w_nxt     = S_FAULT;
            w_err_set = 1'b1;
          end else begin
            w_tmo_dec = 1'b1;
`endif
          end
        end
        S_RUN:   w_nxt = S_RUN;
        S_FAULT: w_nxt = S_FAULT;
        default: w_nxt = S_WAIT_LOCK;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge.
  assign w_periph_on = (w_nxt != S_WAIT_LOCK) && (w_nxt != S_STABLE);
  assign w_core_on   = (w_nxt == S_REL_CORE) || (w_nxt == S_INIT) ||
                       (w_nxt == S_RUN);

  always_ff @(posedge clk_p or posedge reset_p) begin
    if (reset_p) begin
      r_state      <= S_WAIT_LOCK;
      r_rst_n      <= 1'b0;
      r_core_rst   <= 1'b1;
      r_init_start <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_rst_n      <= w_periph_on;
      r_core_rst   <= !w_core_on;
      r_init_start <= (r_state == S_REL_CORE) && (w_nxt == S_INIT);
      r_ready      <= (w_nxt == S_RUN);
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_p or posedge reset_p) begin
    if (reset_p) begin
      r_init_err <= 1'b0;
    end else if (w_err_set) begin
      r_init_err <= 1'b1;
    end else if (w_err_clr) begin
      r_init_err <= 1'b0;
    end
  end

  assign init_err = r_init_err;
`else
  assign init_err = 1'b0;
`endif

  assign rst_n_out  = r_rst_n;
  assign core_rst   = r_core_rst;
  assign init_start = r_init_start;
  assign ready      = r_ready;
  assign state_o    = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with LOCK=8, HOLD=4, TIMEOUT=32.
// Cycle k means the interval just after the k-th sampling edge.
module tb_rst_seq_ctrl;

  logic       clk_p;
  logic       reset_p;
  logic       clk_locked;
  logic       soft_rst_req;
  logic       init_done;
  logic       rst_n_out;
  logic       core_rst;
  logic       init_start;
  logic       ready;
  logic       init_err;
  logic [2:0] state_o;

  int n_checks;
  int n_fail;

  rst_seq_ctrl #(
    .LOCK_CYCLES    (8),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk_p        (clk_p),
    .reset_p      (reset_p),
    .clk_locked   (clk_locked),
    .soft_rst_req (soft_rst_req),
    .init_done    (init_done),
    .rst_n_out    (rst_n_out),
    .core_rst     (core_rst),
    .init_start   (init_start),
    .ready        (ready),
    .init_err     (init_err),
    .state_o      (state_o)
  );

  initial begin
    clk_p = 1'b0;
    forever #5 clk_p = ~clk_p;
  end

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset_p      = 1'b1;
    clk_locked   = 1'b1;
    soft_rst_req = 1'b0;
    init_done    = 1'b0;
    #12;
    got = {rst_n_out, core_rst, init_start, ready, init_err, 1'b0};
    n_checks++;
    if (got !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_outs got=%b exp=%b", got, 6'b010000);
    end
    n_checks++;
    if (state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=0", state_o);
    end
    reset_p = 1'b0;
  endtask

  task automatic test_cold_boot();
    logic [3:0] got;
    logic [3:0] exp;
    for (int k = 1; k <= 18; k++) begin
      tick();
      got = {rst_n_out, core_rst, init_start, ready};
      exp = {(k >= 9), (k < 13), (k == 14), (k >= 18)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cold_boot k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 1 || k == 9 || k == 13 || k == 14 || k == 18) begin
        n_checks++;
        if (state_o !== ((k == 1) ? 3'd1 : (k == 9) ? 3'd2 :
                         (k == 13) ? 3'd3 : (k == 14) ? 3'd4 : 3'd5)) begin
          n_fail++;
          $display("FAIL cold_state k=%0d got=%0d", k, state_o);
        end
      end
      if (k == 17) init_done = 1'b1;
    end
  endtask

  task automatic test_soft_reset();
    logic [3:0] got;
    logic [3:0] exp;
    soft_rst_req = 1'b1;
    init_done    = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 1) begin
        soft_rst_req = 1'b0;
        n_checks++;
        if (state_o !== 3'd1) begin
          n_fail++;
          $display("FAIL soft_state got=%0d exp=1", state_o);
        end
      end
      got = {rst_n_out, core_rst, init_start, ready};
      exp = {(k >= 9), (k < 13), (k == 14), (k >= 18)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL soft_seq k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 17) init_done = 1'b1;
    end
  endtask

  task automatic test_priority();
    logic [3:0] got;
    soft_rst_req = 1'b1;
    clk_locked   = 1'b0;
    init_done    = 1'b0;
    tick();
    soft_rst_req = 1'b0;
    n_checks++;
    if (state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL priority_state got=%0d exp=0", state_o);
    end
    got = {rst_n_out, core_rst, init_start, ready};
    n_checks++;
    if (got !== 4'b0100) begin
      n_fail++;
      $display("FAIL priority_outs got=%b exp=0100", got);
    end
  endtask

  task automatic test_lock_glitch();
    logic [3:0] got;
    logic [3:0] exp;
    clk_locked = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (state_o !== 3'd1) begin
      n_fail++;
      $display("FAIL glitch_pre got=%0d exp=1", state_o);
    end
    clk_locked = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 3'd0 || rst_n_out !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_drop state=%0d rst_n=%b exp 0/0",
               state_o, rst_n_out);
    end
    clk_locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 3) soft_rst_req = 1'b1;
      if (k == 4) soft_rst_req = 1'b0;
      got = {rst_n_out, core_rst, init_start, ready};
      exp = {(k >= 9), (k < 13), (k == 14), 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL glitch_seq k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    n_checks++;
    if (state_o !== 3'd4) begin
      n_fail++;
      $display("FAIL glitch_init got=%0d exp=4", state_o);
    end
  endtask

  // Continues from INIT entered at k=14 of the lock-glitch run.
  task automatic test_timeout();
    for (int k = 16; k <= 49; k++) begin
      tick();
`ifdef RST_SEQ_TIMEOUT_EN
      if (k == 45) begin
        n_checks++;
        if (state_o !== 3'd4 || init_err !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_early state=%0d err=%b exp 4/0",
                   state_o, init_err);
        end
      end
      if (k == 46 || k == 49) begin
        n_checks++;
        if ({state_o, init_err, core_rst, rst_n_out, ready} !== 7'b1101110) begin
          n_fail++;
          $display("FAIL tmo_fault k=%0d state=%0d err=%b core=%b rst_n=%b rdy=%b",
                   k, state_o, init_err, core_rst, rst_n_out, ready);
        end
      end
`else
      if (k == 46 || k == 49) begin
        n_checks++;
        if (state_o !== 3'd4 || init_err !== 1'b0) begin
          n_fail++;
          $display("FAIL no_tmo k=%0d state=%0d err=%b exp 4/0",
                   k, state_o, init_err);
        end
      end
`endif
    end
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    n_checks++;
    if ({state_o, init_err, rst_n_out, core_rst} !== 6'b001001) begin
      n_fail++;
      $display("FAIL tmo_clear state=%0d err=%b rst_n=%b core=%b",
               state_o, init_err, rst_n_out, core_rst);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (k == 14) begin
        n_checks++;
        if (init_start !== 1'b1 || state_o !== 3'd4) begin
          n_fail++;
          $display("FAIL async_pre istart=%b state=%0d exp 1/4",
                   init_start, state_o);
        end
      end
    end
    n_checks++;
    if ({rst_n_out, core_rst} !== 2'b10) begin
      n_fail++;
      $display("FAIL async_init got=%b exp=10", {rst_n_out, core_rst});
    end
    @(posedge clk_p);
    #2;
    reset_p = 1'b1;
    #1;
    n_checks++;
    if ({rst_n_out, core_rst, init_start, ready, init_err, state_o}
        !== 8'b01000000) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=01000000",
               {rst_n_out, core_rst, init_start, ready, init_err, state_o});
    end
  endtask

  task automatic test_reset_release();
    tick();
    n_checks++;
    if (state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL held_reset got=%0d exp=0", state_o);
    end
    @(negedge clk_p);
    reset_p = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 3'd1 || rst_n_out !== 1'b0) begin
      n_fail++;
      $display("FAIL release state=%0d rst_n=%b exp 1/0", state_o, rst_n_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_cold_boot();
    test_soft_reset();
    test_priority();
    test_lock_glitch();
    test_timeout();
    test_async_reset();
    test_reset_release();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
